// File: rtl/insmem_pkg.sv
// Shared constants and FSM encoding for the instruction memory port.
package insmem_pkg;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {S_IDLE, S_LOAD} state_e;
endpackage

// File: rtl/inst_mem_port_if.sv
// Fetch and loader handshake bundle; master is the core/loader side, slave is the memory.
interface inst_mem_port_if #(parameter int ADDR_W = 8);
  logic              FetchReq;
  logic [ADDR_W-1:0] FetchAddr;
  logic              FetchReady;
  logic              FetchValid;
  logic [31:0]       FetchData;
  logic              FetchMisalign;
  logic              LoadStart;
  logic [ADDR_W-1:0] LoadBase;
  logic              LoadValid;
  logic [7:0]        LoadByte;
  logic              LoadLast;
  logic              LoadReady;
  logic              LoadDone;
  logic              LoadErr;
  logic [ADDR_W:0]   LoadCount;

  modport master (
    output FetchReq, FetchAddr, LoadStart, LoadBase, LoadValid, LoadByte, LoadLast,
    input  FetchReady, FetchValid, FetchData, FetchMisalign,
           LoadReady, LoadDone, LoadErr, LoadCount
  );
  modport slave (
    input  FetchReq, FetchAddr, LoadStart, LoadBase, LoadValid, LoadByte, LoadLast,
    output FetchReady, FetchValid, FetchData, FetchMisalign,
           LoadReady, LoadDone, LoadErr, LoadCount
  );
endinterface

// File: rtl/insmem_byte_ram.sv
// Byte-wide program RAM: one byte write port, one registered 4-byte big-endian read port.
module insmem_byte_ram #(parameter int ADDR_W = 8) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Lowest address lands in the top byte; only the output register is reset.
  always_ff @(posedge clk)
    if (rst)     rdata <= '0;
    else if (re)
      for (int b = 0; b < 4; b++)
        rdata[31-8*b -: 8] <= mem[raddr + ADDR_W'(b)];
endmodule

// File: rtl/inst_mem_port.sv
// Instruction memory with registered fetch port and byte-stream program loader.
// Optional INSMEM_MISALIGN_TRAP_EN: unaligned fetches return a NOP with FetchMisalign set.
module inst_mem_port #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  inst_mem_port_if.slave   bus
);
  import insmem_pkg::*;

  state_e            state_q, state_d;
  logic              rdy_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              err_q, done_q, fvld_q;
  logic              fetch_rdy, load_rdy;
  logic              fetch_acc, start_acc, byte_acc, ptr_end, misalign;
  logic [INSTR_W-1:0] rd_word;

  assign ptr_end   = &ptr_q;
  assign fetch_acc = bus.FetchReq & fetch_rdy;
  assign start_acc = bus.LoadStart & fetch_rdy;
  assign byte_acc  = bus.LoadValid & load_rdy;

`ifdef INSMEM_MISALIGN_TRAP_EN
  assign misalign = |bus.FetchAddr[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge CLK)
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;

  // rdy_q keeps both ready outputs low for the first cycle out of reset.
  always_comb begin
    state_d   = state_q;
    fetch_rdy = 1'b0;
    load_rdy  = 1'b0;
    case (state_q)
      S_IDLE: begin
        fetch_rdy = rdy_q;
        if (rdy_q && bus.LoadStart) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_rdy = rdy_q;
        if (rdy_q && bus.LoadValid && (bus.LoadLast || ptr_end)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK)
    if (Reset) begin
      rdy_q  <= 1'b0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      fvld_q <= 1'b0;
    end else begin
      rdy_q  <= 1'b1;
      fvld_q <= fetch_acc;
      done_q <= byte_acc && (bus.LoadLast || ptr_end);
      if (start_acc) begin
        ptr_q <= bus.LoadBase;
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (byte_acc) begin
        ptr_q <= ptr_q + 1'b1;
        cnt_q <= cnt_q + 1'b1;
        // Last address reached without LoadLast: stop instead of wrapping.
        if (ptr_end && !bus.LoadLast) err_q <= 1'b1;
      end
    end

  insmem_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .rst   (Reset),
    .we    (byte_acc),
    .waddr (ptr_q),
    .wdata (bus.LoadByte),
    .re    (fetch_acc & ~misalign),
    .raddr (bus.FetchAddr & ~ADDR_W'(3)),
    .rdata (rd_word)
  );

`ifdef INSMEM_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge CLK)
    if (Reset)          mis_q <= 1'b0;
    else if (fetch_acc) mis_q <= misalign;
  assign bus.FetchData     = mis_q ? NOP_INSTR : rd_word;
  assign bus.FetchMisalign = mis_q;
`else
  assign bus.FetchData     = rd_word;
  assign bus.FetchMisalign = 1'b0;
`endif

  assign bus.FetchReady = fetch_rdy;
  assign bus.LoadReady  = load_rdy;
  assign bus.FetchValid = fvld_q;
  assign bus.LoadDone   = done_q;
  assign bus.LoadErr    = err_q;
  assign bus.LoadCount  = cnt_q;
endmodule

// File: tb/tb_inst_mem_port.sv
// Scoreboard bench for inst_mem_port: byte-array reference model, queued fetch expectations.
module tb_inst_mem_port;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  typedef struct { logic [31:0] data; logic mis; } exp_t;

  logic CLK = 1'b0;
  logic Reset;
  inst_mem_port_if #(.ADDR_W(ADDR_W)) bus ();

  inst_mem_port #(.ADDR_W(ADDR_W), .INSTR_W(32)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] model [DEPTH];
  exp_t       exp_q [$];
  logic [7:0] pat [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_word(input logic [7:0] a);
    exp_t       e;
    logic [7:0] b;
    b = a & 8'hFC;
    e.data = {model[b], model[b+1], model[b+2], model[b+3]};
    e.mis  = 1'b0;
`ifdef INSMEM_MISALIGN_TRAP_EN
    if (a[1:0] != 2'b00) begin
      e.data = 32'h0000_0013;
      e.mis  = 1'b1;
    end
`endif
    return e;
  endfunction

  // Monitor: every valid response must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (bus.FetchValid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got data %0h with no fetch outstanding at %0t", bus.FetchData, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.FetchData !== e.data || bus.FetchMisalign !== e.mis) begin
          fails++;
          $display("FAIL fetch_data: got %0h/%b expected %0h/%b at %0t",
                   bus.FetchData, bus.FetchMisalign, e.data, e.mis, $time);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_fetch(input logic [7:0] a);
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = a;
    @(negedge CLK);
    chk("fetch_ready", 32'(bus.FetchReady), 1);
    if (bus.FetchReady) exp_q.push_back(expect_word(a));
    @(posedge CLK); #1;
    bus.FetchReq = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] base, input int n, input bit last,
                         input bit with_fetch, input logic [7:0] faddr);
    int room, cnt;
    bit err;
    room = DEPTH - int'(base);
    cnt  = (n < room) ? n : room;
    err  = !(last && n <= room);
    bus.LoadStart = 1'b1;
    bus.LoadBase  = base;
    if (with_fetch) begin
      bus.FetchReq  = 1'b1;
      bus.FetchAddr = faddr;
    end
    @(negedge CLK);
    chk("start_ready", 32'(bus.FetchReady), 1);
    if (with_fetch && bus.FetchReady) exp_q.push_back(expect_word(faddr));
    @(posedge CLK); #1;
    bus.LoadStart = 1'b0;
    for (int i = 0; i <= n; i++) begin
      bus.FetchReq = with_fetch && (i == 0);
      if (i < n) begin
        bus.LoadValid = 1'b1;
        bus.LoadByte  = (i < pat.size()) ? pat[i] : 8'($urandom);
        bus.LoadLast  = last && (i == n - 1);
      end else begin
        bus.LoadValid = 1'b0;
        bus.LoadLast  = 1'b0;
      end
      @(negedge CLK);
      if (i < n) chk("load_ready", 32'(bus.LoadReady), 32'(i < cnt));
      chk("fetch_ready_in_load", 32'(bus.FetchReady), 32'(i >= cnt));
      chk("load_done", 32'(bus.LoadDone), 32'(i == cnt));
      if (i < n && bus.LoadReady) model[int'(base) + i] = bus.LoadByte;
      @(posedge CLK); #1;
    end
    bus.LoadValid = 1'b0;
    bus.FetchReq  = 1'b0;
    chk("load_count", 32'(bus.LoadCount), cnt);
    chk("load_err", 32'(bus.LoadErr), 32'(err));
  endtask

  task automatic chk_reset_vals();
    chk("rst_fetch_ready", 32'(bus.FetchReady), 0);
    chk("rst_fetch_valid", 32'(bus.FetchValid), 0);
    chk("rst_fetch_data", bus.FetchData, 0);
    chk("rst_misalign", 32'(bus.FetchMisalign), 0);
    chk("rst_load_ready", 32'(bus.LoadReady), 0);
    chk("rst_load_done", 32'(bus.LoadDone), 0);
    chk("rst_load_err", 32'(bus.LoadErr), 0);
    chk("rst_load_count", 32'(bus.LoadCount), 0);
  endtask

  initial begin
    Reset = 1'b1;
    bus.FetchReq = 1'b0; bus.FetchAddr = '0;
    bus.LoadStart = 1'b0; bus.LoadBase = '0;
    bus.LoadValid = 1'b0; bus.LoadByte = '0; bus.LoadLast = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_vals();
    Reset = 1'b0;
    @(posedge CLK); #1;
    chk("ready_after_reset", 32'(bus.FetchReady), 1);

    // Fill the whole memory so every fetch has a known reference value.
    do_load(8'h00, DEPTH, 1'b1, 1'b0, 8'h00);

    pat = '{8'h00, 8'h80, 8'h00, 8'h93};
    do_load(8'h00, 4, 1'b1, 1'b0, 8'h00);
    pat.delete();
    chk("model_word0", {model[0], model[1], model[2], model[3]}, 32'h0080_0093);
    do_fetch(8'h00);

    // Ten back-to-back fetches with FetchReq held high.
    for (int i = 0; i < 10; i++) begin
      bus.FetchReq  = 1'b1;
      bus.FetchAddr = 8'(4 * i);
      @(negedge CLK);
      chk("b2b_ready", 32'(bus.FetchReady), 1);
      if (i > 0) chk("b2b_valid", 32'(bus.FetchValid), 1);
      if (bus.FetchReady) exp_q.push_back(expect_word(8'(4 * i)));
      @(posedge CLK); #1;
    end
    bus.FetchReq = 1'b0;

    do_load(8'hFE, 3, 1'b0, 1'b0, 8'h00);
    do_fetch(8'hFC);
    do_fetch(8'h06);
    do_fetch(8'h07);

    // Reset in the middle of a load.
    bus.LoadStart = 1'b1; bus.LoadBase = 8'h40;
    @(posedge CLK); #1;
    bus.LoadStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadByte  = 8'($urandom);
      @(negedge CLK);
      chk("mid_load_ready", 32'(bus.LoadReady), 1);
      if (bus.LoadReady) model[8'h40 + i] = bus.LoadByte;
      @(posedge CLK); #1;
    end
    bus.LoadValid = 1'b0;
    Reset = 1'b1;
    @(posedge CLK); #1;
    chk_reset_vals();
    Reset = 1'b0;
    @(negedge CLK);
    chk("ready_low_first", 32'(bus.FetchReady), 0);
    @(posedge CLK); #1;
    chk("ready_rise", 32'(bus.FetchReady), 1);
    do_fetch(8'h40);
    do_fetch(8'h44);

    // Simultaneous LoadStart and FetchReq: fetch sees the pre-load contents.
    do_load(8'h10, 4, 1'b1, 1'b1, 8'h10);
    do_fetch(8'h10);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: do_load(8'($urandom_range(0, 255)), $urandom_range(1, 8), 1'b1, 1'b0, 8'h00);
        1: begin
          logic [7:0] b;
          b = 8'($urandom_range(8'hF8, 8'hFF));
          do_load(b, DEPTH - int'(b) + $urandom_range(0, 2), 1'b0, 1'b0, 8'h00);
        end
        default: do_fetch(8'($urandom));
      endcase
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
